// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// keypad_scanner: 4x4 hex keypad row scanner with whole-scan debounce,
//                 valid/ready key handoff and a 32-bit digit entry register.
// Revision: 1.0
// ============================================================================
module keypad_scanner #(
  parameter int SCAN_INTVL     = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  col_in,
  output logic [3:0]  row_out,
  output logic        key_valid,
  output logic [3:0]  key_code,
  input  logic        key_ready,
  output logic [31:0] entry,
  input  logic        entry_clr,
  output logic        overrun
);

  localparam int CW = (SCAN_INTVL > 1) ? $clog2(SCAN_INTVL) : 1;
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_INTVL - 1);
  localparam logic [DW-1:0] DEB_TARGET = DW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAND    = 2'd1,
    PRESSED = 2'd2
  } state_t;

  logic [3:0]    col_meta;
  logic [3:0]    col_sync;
  logic [CW-1:0] scan_cnt;
  logic [1:0]    row_idx;
  logic          sample;
  logic          scan_done;
  logic [2:0]    row_cnt;
  logic [1:0]    row_col;
  logic [1:0]    acc_cnt;
  logic [3:0]    acc_key;
  logic [1:0]    acc_base;
  logic [2:0]    sum;
  logic [1:0]    tot;
  logic [3:0]    scan_key;
  logic          single;
  state_t        state;
  state_t        state_nxt;
  logic [3:0]    cand;
  logic [3:0]    cand_nxt;
  logic [DW-1:0] deb_cnt;
  logic [DW-1:0] deb_nxt;
  logic [DW-1:0] deb_inc;
  logic          accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta <= 4'hF;
      col_sync <= 4'hF;
    end else begin
      col_meta <= col_in;
      col_sync <= col_meta;
    end
  end

  assign sample    = (scan_cnt == SCAN_LAST);
  assign scan_done = sample && (row_idx == 2'd3);
  assign row_out   = ~(4'b0001 << row_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      row_idx  <= 2'd0;
    end else if (sample) begin
      scan_cnt <= '0;
      row_idx  <= row_idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + CW'(1);
    end
  end

  // Closed keys in the current row; row_col is the lowest closed column.
  always_comb begin
    row_cnt = 3'd0;
    row_col = 2'd0;
    for (int c = 3; c >= 0; c--) begin
      if (!col_sync[c]) begin
        row_cnt = row_cnt + 3'd1;
        row_col = 2'(c);
      end
    end
  end

  // Running key count for the scan saturates at 2, which already means MULTI.
  assign acc_base = (row_idx == 2'd0) ? 2'd0 : acc_cnt;
  assign sum      = {1'b0, acc_base} + row_cnt;
  assign tot      = (sum >= 3'd2) ? 2'd2 : sum[1:0];
  assign scan_key = (row_cnt == 3'd1) ? {row_idx, row_col} : acc_key;
  assign single   = scan_done && (tot == 2'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt <= 2'd0;
      acc_key <= 4'd0;
    end else if (sample) begin
      acc_cnt <= tot;
      acc_key <= scan_key;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cand    <= 4'd0;
      deb_cnt <= '0;
    end else begin
      state   <= state_nxt;
      cand    <= cand_nxt;
      deb_cnt <= deb_nxt;
    end
  end

  assign deb_inc = deb_cnt + DW'(1);

  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    deb_nxt   = deb_cnt;
    accept    = 1'b0;
    if (scan_done) begin
      case (state)
        IDLE: begin
          if (single) begin
            cand_nxt = scan_key;
            if (DEBOUNCE_SCANS == 1) begin
              accept    = 1'b1;
              state_nxt = PRESSED;
              deb_nxt   = '0;
            end else begin
              state_nxt = CAND;
              deb_nxt   = DW'(1);
            end
          end
        end
        CAND: begin
          if (single && (scan_key == cand)) begin
            if (deb_inc == DEB_TARGET) begin
              accept    = 1'b1;
              state_nxt = PRESSED;
              deb_nxt   = '0;
            end else begin
              deb_nxt = deb_inc;
            end
          end else begin
            state_nxt = IDLE;
            deb_nxt   = '0;
          end
        end
        PRESSED: begin
          // deb_cnt counts consecutive release scans here.
          if (single) begin
            deb_nxt = '0;
          end else if (deb_inc == DEB_TARGET) begin
            state_nxt = IDLE;
            deb_nxt   = '0;
          end else begin
            deb_nxt = deb_inc;
          end
        end
        default: begin
          state_nxt = IDLE;
          deb_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_valid <= 1'b0;
      key_code  <= 4'd0;
      entry     <= 32'd0;
      overrun   <= 1'b0;
    end else begin
      if (accept) begin
        key_valid <= 1'b1;
        key_code  <= scan_key;
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end

      if (entry_clr) begin
        entry <= accept ? {28'h0, scan_key} : 32'd0;
      end else if (accept) begin
        entry <= {entry[27:0], scan_key};
      end

      if (entry_clr) begin
        overrun <= 1'b0;
      end else if (accept && key_valid && !key_ready) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix hex keypad by driving one row low at a time and sampling the four column lines. Debounces each press over whole scans and encodes the key as a 4-bit hex code. Shifts every accepted key into a 32-bit entry register, and hands each key to the CPU side through a valid/ready handshake. It is the input-side counterpart of the board's seven-segment display driver: the user types a 32-bit value here, and the display shows it back.

## Interface
- `SCAN_INTVL`, 100000: clock cycles each row stays driven (minimum 4).
- `DEBOUNCE_SCANS`, 4: consecutive identical full scans needed to accept a press or a release (minimum 1).
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `col_in`  in  4  keypad column lines, active-low (pulled up, 0 = key closed in the driven row); asynchronous to `clk`.
- `row_out`  out  4  keypad row drive, active-low one-hot; bit r low = row r driven.
- `key_valid`  out  1  a key code is pending.
- `key_code`  out  4  code of the pending key; `key_code` = 4*row + col.
- `key_ready`  in  1  consumer accepts the pending key.
- `entry`  out  32  accumulated digits; the newest digit is in [3:0].
- `entry_clr`  in  1  synchronous clear of `entry` and `overrun`.
- `overrun`  out  1  sticky flag; set when a key is accepted while `key_valid` is still high.

## Operation
- **Column sync:** `col_in` passes through a two-flop synchronizer. Only the synchronized value is used.
- **Row scan:**
  - A counter runs 0..SCAN_INTVL-1 for each row. Rows advance 0,1,2,3,0,...
  - Row patterns: row 0 = 4'b1110, row 1 = 1101, row 2 = 1011, row 3 = 0111.
  - Columns are sampled at counter value SCAN_INTVL-1 of each row. The row advances on the next cycle.
- **Scan result** (formed at the row-3 sample, from all 16 samples):
  - NONE: no closed keys.
  - SINGLE(k): exactly one closed key.
  - MULTI: two or more closed keys; handled exactly as NONE.
- **FSM**, evaluated once per completed scan:
  - IDLE:
    - SINGLE(k) → CAND, with cand=k and cnt=1.
    - If DEBOUNCE_SCANS=1, go straight to PRESSED and accept k.
  - CAND:
    - SINGLE(cand) → cnt+1. When cnt reaches DEBOUNCE_SCANS, accept cand and go to PRESSED.
    - Any other result → IDLE.
  - PRESSED:
    - Count consecutive NONE/MULTI scans. After DEBOUNCE_SCANS of them → IDLE.
    - Any SINGLE (same key or a different one) restarts the release count.
    - A new key cannot be accepted until release completes.
- **Accept** (all in one cycle):
  - `key_code` ← k and `key_valid` ← 1.
  - `entry` ← {entry[27:0], k}; the oldest digit drops out.
  - If `key_valid` was already 1 and is not being consumed this cycle, `overrun` ← 1. The new code overwrites the old one.
- **Handshake:**
  - `key_valid` falls on the cycle after a cycle where `key_valid` & `key_ready` are both high.
  - If an accept coincides with consumption, `key_valid` stays 1 with the new code, and `overrun` is not set.
  - `key_code` holds its value after consumption.
- **entry_clr:**
  - `entry` ← 0 and `overrun` ← 0.
  - If an accept happens in the same cycle, `entry` ← {28'h0, k}; `overrun` is still cleared.
  - The handshake and the FSM are unaffected.

## Timing
- Reset values (while `rst_n` is low, immediately and asynchronously):
  - `row_out` = 4'b1110, `key_valid` = 0, `key_code` = 0, `entry` = 0, `overrun` = 0.
  - FSM = IDLE; scan and debounce counters = 0; synchronizer = 4'hF.
- One full scan takes 4*SCAN_INTVL cycles.
- The column-to-sample path is 2 cycles of synchronizer latency. A row change is seen by the sampled columns 3 cycles later, well inside SCAN_INTVL ≥ 4.
- Accept latency: `key_valid` rises 1 cycle after the row-3 sample of the DEBOUNCE_SCANS-th identical scan.
- Reset asserted mid-debounce or mid-press abandons the press. After release of reset, scanning restarts at row 0, counter 0.

## Test plan
Bench parameters: SCAN_INTVL=4, DEBOUNCE_SCANS=2 (one scan = 16 cycles). The keypad model pulls a column low only while the key's row bit in `row_out` is low.
- **Reset:** pulse `rst_n` low mid-scan → outputs at their reset values at once; `row_out` steps 1110→1101→1011→0111 every 4 cycles.
- **Single press:** press row 2 / col 1 for 5 scans, `key_ready`=1, then release → exactly one 1-cycle `key_valid`; `key_code`=9; `entry`=32'h00000009; `overrun`=0.
- **Bounce:** press lasting 1 scan only → no `key_valid`. A MULTI press (codes 2 and 7) held for 5 scans → no `key_valid`, `entry` unchanged.
- **Sequence:** keys 1,2,3 each pressed for 4 scans and released for 4 scans, then keys 4..F,0 → `entry`=32'h00000123 after three keys. After the full run, `entry` holds the last 8 codes.
- **Overrun:** `key_ready`=0, press 5 then 6 → `key_code`=6, `overrun`=1. `entry_clr` pulse → `entry`=0, `overrun`=0, `key_valid` still 1. `key_ready` pulse → `key_valid` falls next cycle.
- **Corner cases:**
  - Press during PRESSED is ignored until release.
  - `entry_clr` in the accept cycle → `entry`=32'h0000000k.
  - `rst_n` low during CAND → no accept afterwards without a fresh debounced press.
